// File: rtl/ram_reader.sv
// -----------------------------------------------------------------------------
// ram_reader
//
// Owns the 32-location frame RAM. The write side fills it at any time, and on
// command this block plays back a run of 1..32 words starting at any base
// address. Playback goes to a downstream consumer over a valid/ready handshake.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   res        asynchronous active-high reset
//   wr_en      write strobe; writes wr_data to mem[wr_addr] on the edge
//   wr_addr    write address (5 bits)
//   wr_data    write data (WIDTH bits)
//   start      playback request, sampled only while idle
//   base       first read address, sampled with start
//   len        word count, sampled with start (0 = ignore, >32 treated as 32)
//   rd_addr    address of the word being fetched or presented
//   dout       playback data
//   dout_valid dout holds a word for the consumer
//   dout_ready consumer accepts dout
//   busy       playback in progress
//   done       one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module ram_reader #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32
) (
   input  logic             clk,
   input  logic             res,
   input  logic             wr_en,
   input  logic [4:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             start,
   input  logic [4:0]       base,
   input  logic [5:0]       len,
   output logic [4:0]       rd_addr,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_PRESENT = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   // Storage is deliberately left out of reset so a reset mid-playback keeps
   // the frame intact.
   logic [WIDTH-1:0] r_mem [DEPTH];

   state_t           r_state;
   logic [5:0]       r_remaining;
   logic [4:0]       r_rd_addr;
   logic [WIDTH-1:0] r_dout;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;

   logic [5:0]       w_len_clamped;
   logic             w_accept;

   // Requests longer than the RAM are clamped to one full pass.
   assign w_len_clamped = (len > 6'd32) ? 6'd32 : len;
   assign w_accept      = r_valid & dout_ready;

   // Write port runs independently of the playback state machine.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_state     <= S_IDLE;
         r_remaining <= 6'd0;
         r_rd_addr   <= 5'd0;
         r_dout      <= '0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && (len != 6'd0)) begin
                  r_rd_addr   <= base;
                  r_remaining <= w_len_clamped;
                  r_busy      <= 1'b1;
                  r_state     <= S_FETCH;
               end
            end

            // Nonblocking read of r_mem gives read-before-write when the
            // write side hits the same address on this edge.
            S_FETCH: begin
               r_dout  <= r_mem[r_rd_addr];
               r_valid <= 1'b1;
               r_state <= S_PRESENT;
            end

            // dout and rd_addr stay frozen until the consumer takes the word.
            S_PRESENT: begin
               if (w_accept) begin
                  r_valid     <= 1'b0;
                  r_remaining <= r_remaining - 6'd1;
                  if (r_remaining == 6'd1) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_rd_addr <= r_rd_addr + 5'd1;  // wraps 31 -> 0
                     r_state   <= S_FETCH;
                  end
               end
            end

            // start is not looked at here, so a request during DONE is dropped.
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign rd_addr    = r_rd_addr;
   assign dout       = r_dout;
   assign dout_valid = r_valid;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_ram_reader.sv
// -----------------------------------------------------------------------------
// tb_ram_reader
//
// Self-checking bench for ram_reader. Each scenario task pushes the expected
// playback words into a scoreboard queue, drives the command, and compares the
// words the DUT hands over against the queue.
// -----------------------------------------------------------------------------
module tb_ram_reader;

   logic       clk = 1'b0;
   logic       res;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic       start;
   logic [4:0] base;
   logic [5:0] len;
   logic [4:0] rd_addr;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic       busy;
   logic       done;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_d [$];
   logic [4:0] exp_a [$];
   logic [7:0] obs_d [$];
   logic [4:0] obs_a [$];
   int         n_done;
   int         done_cyc;
   int         idle_cyc;
   bit         timed_out;

   always #5 clk = ~clk;

   ram_reader #(.WIDTH(8), .DEPTH(32)) dut (
      .clk        (clk),
      .res        (res),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .start      (start),
      .base       (base),
      .len        (len),
      .rd_addr    (rd_addr),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy),
      .done       (done)
   );

   // Runs the clock with ready high, recording every accepted word, until the
   // DUT returns to idle or the budget runs out. start is dropped once idle.
   task automatic collect(input int budget);
      n_done    = 0;
      done_cyc  = -1;
      idle_cyc  = -1;
      timed_out = 1'b1;
      obs_d.delete();
      obs_a.delete();
      dout_ready = 1'b1;
      for (int c = 1; c <= budget; c++) begin
         @(posedge clk); #1;
         if (dout_valid && dout_ready) begin
            obs_d.push_back(dout);
            obs_a.push_back(rd_addr);
         end
         if (done) begin
            n_done++;
            done_cyc = c;
         end
         if (!busy) begin
            start     = 1'b0;
            idle_cyc  = c;
            timed_out = 1'b0;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic write_word(input logic [4:0] a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(posedge clk); #1;
      wr_en   = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({rd_addr, dout, dout_valid, busy, done} !== 16'h0000) begin
         failures++;
         $display("FAIL reset_outputs: got rd_addr=%0h dout=%0h valid=%0b busy=%0b done=%0b required all 0",
                  rd_addr, dout, dout_valid, busy, done);
      end
   endtask

   task automatic test_full_run();
      logic [7:0] e_d;
      logic [4:0] e_a;
      for (int i = 0; i < 32; i++) begin
         write_word(5'(i), 8'(8'h40 + i));
      end
      for (int i = 0; i < 32; i++) begin
         exp_d.push_back(8'(8'h40 + i));
         exp_a.push_back(5'(i));
      end
      base = 5'd0; len = 6'd32; start = 1'b1;
      collect(200);
      checks++;
      if (timed_out || obs_d.size() != exp_d.size()) begin
         failures++;
         $display("FAIL full_count: got %0d words timeout=%0b required %0d", obs_d.size(), timed_out, exp_d.size());
      end
      while (exp_d.size() > 0 && obs_d.size() > 0) begin
         e_d = exp_d.pop_front(); e_a = exp_a.pop_front();
         checks++;
         if (obs_d[0] !== e_d || obs_a[0] !== e_a) begin
            failures++;
            $display("FAIL full_word: got dout=%0h addr=%0d required dout=%0h addr=%0d", obs_d[0], obs_a[0], e_d, e_a);
         end
         void'(obs_d.pop_front()); void'(obs_a.pop_front());
      end
      exp_d.delete(); exp_a.delete();
      checks++;
      if (n_done !== 1 || done_cyc !== 65 || idle_cyc !== 66) begin
         failures++;
         $display("FAIL full_done_timing: got pulses=%0d done_cycle=%0d idle_cycle=%0d required 1/65/66",
                  n_done, done_cyc, idle_cyc);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] e_d;
      logic [4:0] e_a;
      exp_d = '{8'h5E, 8'h5F, 8'h40, 8'h41};
      exp_a = '{5'd30, 5'd31, 5'd0, 5'd1};
      base = 5'd30; len = 6'd4; start = 1'b1;
      collect(40);
      checks++;
      if (timed_out || obs_d.size() != exp_d.size()) begin
         failures++;
         $display("FAIL wrap_count: got %0d words timeout=%0b required %0d", obs_d.size(), timed_out, exp_d.size());
      end
      while (exp_d.size() > 0 && obs_d.size() > 0) begin
         e_d = exp_d.pop_front(); e_a = exp_a.pop_front();
         checks++;
         if (obs_d[0] !== e_d || obs_a[0] !== e_a) begin
            failures++;
            $display("FAIL wrap_word: got dout=%0h addr=%0d required dout=%0h addr=%0d", obs_d[0], obs_a[0], e_d, e_a);
         end
         void'(obs_d.pop_front()); void'(obs_a.pop_front());
      end
      exp_d.delete(); exp_a.delete();
      checks++;
      if (n_done !== 1 || done_cyc !== 9) begin
         failures++;
         $display("FAIL wrap_done: got pulses=%0d cycle=%0d required 1/9", n_done, done_cyc);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] e_d;
      logic [4:0] e_a;
      int         words;
      int         pulses;
      bit         finished;
      exp_d = '{8'h45, 8'h46, 8'h47};
      exp_a = '{5'd5, 5'd6, 5'd7};
      words = 0; pulses = 0; finished = 1'b0;
      dout_ready = 1'b1;
      base = 5'd5; len = 6'd3; start = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (dout_valid) begin
            checks++;
            if (exp_d.size() == 0) begin
               failures++;
               $display("FAIL bp_extra_word: got dout=%0h required no more words", dout);
            end else begin
               e_d = exp_d.pop_front(); e_a = exp_a.pop_front();
               if (dout !== e_d || rd_addr !== e_a) begin
                  failures++;
                  $display("FAIL bp_word: got dout=%0h addr=%0d required dout=%0h addr=%0d", dout, rd_addr, e_d, e_a);
               end
            end
            words++;
            if (words == 2) begin
               // Stall on the second word and overwrite its RAM location.
               dout_ready = 1'b0;
               wr_en = 1'b1; wr_addr = 5'd6; wr_data = 8'h99;
               for (int k = 0; k < 4; k++) begin
                  @(posedge clk); #1;
                  wr_en = 1'b0;
                  checks++;
                  if (dout_valid !== 1'b1 || dout !== 8'h46 || rd_addr !== 5'd6) begin
                     failures++;
                     $display("FAIL bp_stall_hold: got valid=%0b dout=%0h addr=%0d required 1/46/6",
                              dout_valid, dout, rd_addr);
                  end
               end
               dout_ready = 1'b1;
            end
         end
         if (done) pulses++;
         if (!busy) begin
            finished = 1'b1;
            break;
         end
      end
      checks++;
      if (!finished || words !== 3 || pulses !== 1) begin
         failures++;
         $display("FAIL bp_summary: got finished=%0b words=%0d pulses=%0d required 1/3/1", finished, words, pulses);
      end
      exp_d.delete(); exp_a.delete();
      write_word(5'd6, 8'h46);
   endtask

   task automatic test_collision();
      base = 5'd7; len = 6'd1; start = 1'b1; dout_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || dout_valid !== 1'b0) begin
         failures++;
         $display("FAIL fetch_state: got busy=%0b valid=%0b required 1/0", busy, dout_valid);
      end
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 8'hAA;
      @(posedge clk); #1;
      wr_en = 1'b0;
      checks++;
      if (dout_valid !== 1'b1 || dout !== 8'h47) begin
         failures++;
         $display("FAIL collision_old_data: got valid=%0b dout=%0h required 1/47", dout_valid, dout);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || dout_valid !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL collision_done: got done=%0b valid=%0b busy=%0b required 1/0/1", done, dout_valid, busy);
      end
      @(posedge clk); #1;
      // The colliding write must still have landed.
      exp_d.push_back(8'hAA);
      base = 5'd7; len = 6'd1; start = 1'b1;
      collect(20);
      checks++;
      if (timed_out || obs_d.size() != 1 || obs_d[0] !== exp_d[0]) begin
         failures++;
         $display("FAIL collision_write_landed: got %0d words first=%0h required 1 word %0h",
                  obs_d.size(), (obs_d.size() > 0) ? obs_d[0] : 8'h00, exp_d[0]);
      end
      exp_d.delete();
      write_word(5'd7, 8'h47);
   endtask

   task automatic test_ignored_commands();
      logic [7:0] e_d;
      // start held through the whole run with different parameters.
      exp_d = '{8'h40, 8'h41};
      exp_a = '{5'd0, 5'd1};
      base = 5'd0; len = 6'd2; start = 1'b1; dout_ready = 1'b1;
      @(posedge clk); #1;
      base = 5'd20; len = 6'd5;
      collect(40);
      checks++;
      if (timed_out || obs_d.size() != exp_d.size() || n_done !== 1) begin
         failures++;
         $display("FAIL busy_start_count: got %0d words pulses=%0d required 2 words 1 pulse", obs_d.size(), n_done);
      end
      while (exp_d.size() > 0 && obs_d.size() > 0) begin
         e_d = exp_d.pop_front(); void'(exp_a.pop_front());
         checks++;
         if (obs_d[0] !== e_d) begin
            failures++;
            $display("FAIL busy_start_word: got %0h required %0h", obs_d[0], e_d);
         end
         void'(obs_d.pop_front()); void'(obs_a.pop_front());
      end
      exp_d.delete(); exp_a.delete();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || rd_addr !== 5'd1) begin
         failures++;
         $display("FAIL busy_start_no_restart: got busy=%0b addr=%0d required 0/1", busy, rd_addr);
      end
      // len = 0 is a no-op.
      base = 5'd9; len = 6'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || dout_valid !== 1'b0 || rd_addr !== 5'd1) begin
         failures++;
         $display("FAIL len_zero: got busy=%0b valid=%0b addr=%0d required 0/0/1", busy, dout_valid, rd_addr);
      end
      // len = 40 clamps to a single full pass.
      for (int i = 0; i < 32; i++) exp_d.push_back(8'(8'h40 + i));
      base = 5'd0; len = 6'd40; start = 1'b1;
      collect(200);
      checks++;
      if (timed_out || obs_d.size() != 32 || n_done !== 1 || done_cyc !== 65) begin
         failures++;
         $display("FAIL len_clamp: got words=%0d pulses=%0d done_cycle=%0d required 32/1/65",
                  obs_d.size(), n_done, done_cyc);
      end
      while (exp_d.size() > 0 && obs_d.size() > 0) begin
         e_d = exp_d.pop_front();
         checks++;
         if (obs_d[0] !== e_d) begin
            failures++;
            $display("FAIL len_clamp_word: got %0h required %0h", obs_d[0], e_d);
         end
         void'(obs_d.pop_front()); void'(obs_a.pop_front());
      end
      exp_d.delete();
   endtask

   task automatic test_reset_mid();
      int pulses;
      base = 5'd2; len = 6'd4; start = 1'b1; dout_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (dout_valid !== 1'b1 || dout !== 8'h42) begin
         failures++;
         $display("FAIL mid_present: got valid=%0b dout=%0h required 1/42", dout_valid, dout);
      end
      res = 1'b1;
      #1;
      checks++;
      if (dout_valid !== 1'b0 || busy !== 1'b0 || dout !== 8'h00 || rd_addr !== 5'd0) begin
         failures++;
         $display("FAIL mid_reset_abort: got valid=%0b busy=%0b dout=%0h addr=%0d required 0/0/0/0",
                  dout_valid, busy, dout, rd_addr);
      end
      @(posedge clk); #1;
      res = 1'b0;
      dout_ready = 1'b1;
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (done || busy) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         failures++;
         $display("FAIL mid_reset_no_done: got %0d active cycles required 0", pulses);
      end
      // RAM must survive the reset.
      exp_d.push_back(8'h43);
      base = 5'd3; len = 6'd1; start = 1'b1;
      collect(20);
      checks++;
      if (timed_out || obs_d.size() != 1 || obs_d[0] !== exp_d[0]) begin
         failures++;
         $display("FAIL mid_reset_ram_kept: got %0d words first=%0h required 1 word %0h",
                  obs_d.size(), (obs_d.size() > 0) ? obs_d[0] : 8'h00, exp_d[0]);
      end
      exp_d.delete();
   endtask

   initial begin
      res = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 8'h00;
      start = 1'b0; base = 5'd0; len = 6'd0; dout_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      res = 1'b0;
      @(posedge clk); #1;
      test_full_run();
      test_wrap();
      test_backpressure();
      test_collision();
      test_ignored_commands();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_reader.md
# ram_reader

Read-side controller for the 32-location frame RAM. The write side streams words in at addresses supplied by the team's 5-bit address counter. This block owns the storage, accepts those writes, and on command plays back a run of 1–32 words starting at any base address. Playback uses a valid/ready handshake toward the downstream consumer.

## Interface
Parameters:
- WIDTH, 8, data word width
- DEPTH, 32, number of RAM locations (fixed; address is 5 bits)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- res  in  1  reset, asynchronous, active-high; one clock, reset is asynchronous and active-high
- wr_en  in  1  write strobe from the write side
- wr_addr  in  5  write address (driven by the write-side address counter)
- wr_data  in  WIDTH  write data
- start  in  1  playback request, sampled only in IDLE
- base  in  5  first read address, sampled with start
- len  in  6  word count, sampled with start; 0 = ignore, 33–63 clamped to 32
- rd_addr  out  5  current read address
- dout  out  WIDTH  playback data
- dout_valid  out  1  dout holds a valid word
- dout_ready  in  1  consumer accepts dout
- busy  out  1  playback in progress (state not IDLE)
- done  out  1  one-cycle pulse after last word accepted

## Operation
- Storage: DEPTH×WIDTH register array, not reset (contents undefined until written).
- Write port is always active, independent of FSM state: wr_en=1 writes wr_data to mem[wr_addr] at the clock edge.
- Read is synchronous: mem[rd_addr] is registered into dout on the edge leaving FETCH.
- Internal counter `remaining` is 6 bits, range 0–32.
- FSM states: IDLE, FETCH, PRESENT, DONE.
  - IDLE: busy=0, dout_valid=0.
    - start=1 and len≠0: rd_addr←base, remaining←min(len,32), go to FETCH.
    - start=1 and len=0: no effect.
  - FETCH: dout←mem[rd_addr], go to PRESENT.
  - PRESENT: dout_valid=1; dout and rd_addr are held stable until accepted.
    - On dout_valid&dout_ready with remaining=1: go to DONE.
    - On dout_valid&dout_ready otherwise: remaining−1, rd_addr+1 (modulo 32, 31→0), go to FETCH.
  - DONE: done=1 for exactly one cycle, go to IDLE. rd_addr keeps its last value.
- start outside IDLE (including DONE) is ignored; it is not queued.
- Write/read collision: a write to mem[rd_addr] on the same edge the FETCH read occurs returns the OLD data (read-before-write). Writes after capture do not change a presented dout.
- Reset mid-playback: aborts immediately, no done pulse, RAM contents preserved.

## Timing
- Reset values: rd_addr=0, dout=0, dout_valid=0, busy=0, done=0; state IDLE, remaining=0.
- start edge → busy=1 next cycle (FETCH) → dout_valid=1 the cycle after. First-word latency is 2 cycles.
- With dout_ready held high, sustained throughput is 1 word per 2 cycles (FETCH, PRESENT alternate).
- A run of N words with ready always high takes 2N cycles from FETCH entry to DONE. done is asserted in cycle 2N+1 after start, then busy=0 the following cycle.
- dout_ready low stalls indefinitely in PRESENT; dout and rd_addr are unchanged during the stall.
- dout_valid is never asserted in FETCH, DONE or IDLE.

## Test plan
- Reset with all inputs X-free: all outputs 0, busy=0. Assert res mid-PRESENT: next sample shows dout_valid=0, busy=0, done never pulses.
- Write mem[i]=i+8'h40 for i=0..31, start base=0 len=32, ready=1: dout sequence 40..5F, done pulses exactly once 65 cycles after start, then busy=0.
- Wrap: base=30, len=4 → rd_addr 30,31,0,1; dout 5E,5F,40,41.
- Backpressure: base=5, len=3, ready low 4 cycles on word 2: dout=46 held stable with valid high throughout; all 3 words delivered in order.
- Collision/ignored commands: write mem[7]=AA on the FETCH edge for rd_addr=7 → dout=47 (old data). start during busy → no restart. len=0 → busy stays 0. len=40 → exactly 32 words.
